// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the only arithmetic cell used by the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: adds a + b + cin one bit per cycle through a single full adder,
// presenting sum/cout/ovf together with a one-cycle done pulse.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_shifted;

    full_adder u_full_adder (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the MSB so the word is LSB-aligned after WIDTH shifts.
    assign sum_shifted = WIDTH'({fa_sum, sum_sh_q} >> 1);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d  = StAdd;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    sum_sh_d = '0;
                    carry_d  = cin;
                    cnt_d    = '0;
                end
            end
            StAdd: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_shifted;
                carry_d  = fa_carry;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q is the carry into the MSB on this last bit
                    state_d = StDone;
                    sum_d   = sum_shifted;
                    cout_d  = fa_carry;
                    ovf_d   = carry_q ^ fa_carry;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q == StAdd);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int n_checks = 0;
    int n_pass   = 0;

    serial_adder_ctrl #(
        .WIDTH (8)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after the accepting edge. Samples until done, checks timing and
    // result, then steps one more cycle. With keep set, start stays high and the
    // next operands are presented so the DONE cycle accepts them.
    task automatic wait_result(input string tag, input logic [7:0] es, input logic ec,
                               input logic eo, input bit repulse, input bit keep,
                               input logic [7:0] na, input logic [7:0] nb, input logic nc);
        int  busy_cnt = 0;
        int  lat      = 0;
        bit  got      = 0;
        if (keep) begin
            a = na; b = nb; cin = nc;
        end else begin
            start = 1'b0; a = ~a; b = ~b; cin = ~cin;
        end
        for (int i = 0; i < 20; i++) begin
            lat++;
            if (done) begin
                got = 1;
                break;
            end
            if (busy) busy_cnt++;
            if (repulse && i == 2) begin
                start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
            end
            if (repulse && i == 3) start = 1'b0;
            step();
        end
        check({tag, " done seen"}, 32'(got), 32'd1);
        check({tag, " busy cycles"}, busy_cnt, 8);
        check({tag, " latency"}, lat, 9);
        check({tag, " busy in done"}, 32'(busy), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(ec));
        check({tag, " ovf"}, 32'(ovf), 32'(eo));
        step();
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " next busy"}, 32'(busy), 32'(keep));
        check({tag, " sum held"}, 32'(sum), 32'(es));
    endtask

    task automatic do_op(input string tag, input logic [7:0] oa, input logic [7:0] ob,
                         input logic oc, input logic [7:0] es, input logic ec,
                         input logic eo, input bit repulse);
        start = 1'b1; a = oa; b = ob; cin = oc;
        step();
        wait_result(tag, es, ec, eo, repulse, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        int extra_done;
        rst = 1'b1; start = 1'b1; a = 8'h03; b = 8'h05; cin = 1'b0;

        // Reset holds despite start being high
        repeat (3) step();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);

        // First edge with rst low accepts the pending start
        rst = 1'b0;
        step();
        check("first accept busy", 32'(busy), 32'd1);
        wait_result("add_03_05", 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        do_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_op("repulse_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of an addition aborts it and clears outputs
        do_op("pre_abort", 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        check("abort ovf", 32'(ovf), 32'd0);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) extra_done++;
            step();
        end
        check("abort no done", extra_done, 0);
        do_op("after_abort", 8'h5A, 8'h25, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);

        // Start held high: three back-to-back operations
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b1;
        step();
        wait_result("b2b_1", 8'h31, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC8, 8'h64, 1'b0);
        wait_result("b2b_2", 8'h2C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1);
        wait_result("b2b_3", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
